// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   OP_JAL            : RV32 jal major opcode
//   DEFAULT_RESET_PC  : byte PC loaded on reset unless overridden
//   IF_BITS           : instruction width carried by fetch buffer entries
//   fetch_state_e     : fetch FSM states (RUN, FAULT)
//   fetch_entry_t     : fetch buffer entry {pc, instr, predicted}
//   jal_offset()      : sign-extended J-type immediate of an instruction word
package if_pkg;

    localparam logic [6:0]  OP_JAL           = 7'b1101111;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned IF_BITS          = 32;

    typedef enum logic [0:0] {
        RUN,
        FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [IF_BITS-1:0] instr;
        logic               predicted;
    } fetch_entry_t;

    // J-imm = {imm[20], imm[10:1], imm[11], imm[19:12]} held in word[31:12], LSB zero.
    function automatic logic [31:0] jal_offset(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the instruction fetch unit.
//   imem_addr / imem_data          : word-addressed instruction memory read port
//   redirect_valid / redirect_pc   : PC redirect from execute
//   if_valid / if_ready            : fetch -> decode handshake
//   if_instr / if_pc / if_fault    : head entry payload and fault flag
//   if_predicted                   : head entry caused a jal prediction (JAL_PREDICT_EN only)
// modport master: the fetch unit side. modport slave: memory/execute/decode side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BITS   = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [BITS-1:0]   imem_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [BITS-1:0]   if_instr;
    logic [31:0]       if_pc;
    logic              if_fault;
`ifdef JAL_PREDICT_EN
    logic              if_predicted;
`endif

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_fault
`ifdef JAL_PREDICT_EN
        , output if_predicted
`endif
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_fault
`ifdef JAL_PREDICT_EN
        , input  if_predicted
`endif
    );

endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched entries between instruction memory and decode.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : drop all entries (wins over push/pop)
//   push/wdata : enqueue; accepted when not full, or when full and popping this cycle
//   pop        : dequeue head; ignored when empty
//   rdata      : head entry (undefined content when empty)
//   full/empty : occupancy flags
module fetch_buf #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory, buffers {pc, instr}
// for decode and applies redirects from execute.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : instr_fetch_unit_if.master (imem port, redirect, decode handshake, fault)
// Optional macro JAL_PREDICT_EN: follow jal targets at fetch time and expose if_predicted.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned BITS      = IF_BITS,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_unit_if.master bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  next_pc;
    logic         pred;
    fetch_entry_t push_entry, head;
    logic         buf_full, buf_empty;
    logic         flush, do_push, do_pop;
    logic         run;

    assign run           = (state_q == RUN);
    // Truncation is deliberate: PCs beyond the memory alias back into it.
    assign bus.imem_addr = pc_q[ADDR_W+1:2];

`ifdef JAL_PREDICT_EN
    always_comb begin
        pred    = (bus.imem_data[6:0] == OP_JAL);
        next_pc = pred ? pc_q + jal_offset(bus.imem_data) : pc_q + 32'd4;
    end
`else
    assign pred    = 1'b0;
    assign next_pc = pc_q + 32'd4;
`endif

    always_comb begin
        push_entry.pc        = pc_q;
        push_entry.instr     = bus.imem_data;
        push_entry.predicted = pred;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (bus.redirect_pc[1:0] == 2'b00) pc_d = bus.redirect_pc;
                    else state_d = FAULT;
                end else begin
                    do_pop  = !buf_empty && bus.if_ready;
                    do_push = !buf_full || do_pop;
                    if (do_push) pc_d = next_pc;
                end
            end
            FAULT: begin
                // Buffer is already empty; only an aligned redirect restarts fetch.
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (bus.redirect_pc[1:0] == 2'b00) begin
                        pc_d    = bus.redirect_pc;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    logic [$bits(fetch_entry_t)-1:0] buf_rdata;

    fetch_buf #(
        .DEPTH(BUF_DEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) u_fetch_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .push (do_push),
        .pop  (do_pop),
        .wdata(push_entry),
        .rdata(buf_rdata),
        .full (buf_full),
        .empty(buf_empty)
    );

    assign head         = fetch_entry_t'(buf_rdata);
    assign bus.if_valid = run && !buf_empty;
    assign bus.if_instr = bus.if_valid ? head.instr : '0;
    assign bus.if_pc    = bus.if_valid ? head.pc : 32'h0;
    assign bus.if_fault = (state_q == FAULT);

`ifdef JAL_PREDICT_EN
    assign bus.if_predicted = bus.if_valid && head.predicted;
`else
    logic unused_pred;
    assign unused_pred = head.predicted;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(5), .BITS(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (5),
        .BITS     (32),
        .RESET_PC (32'h0),
        .BUF_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem [32];
    assign bus.imem_data = mem[bus.imem_addr];

`ifdef JAL_PREDICT_EN
    localparam logic [31:0] JT   = 32'h44;
    localparam logic        PRED = 1'b1;
`else
    localparam logic [31:0] JT   = 32'h28;
    localparam logic        PRED = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
        logic [4:0]  eaddr;
        logic        epred;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [4:0] a5(input logic [31:0] pc);
        return pc[6:2];
    endfunction

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic ef,
                       input logic [4:0] eaddr, input logic epred);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = eaddr; v.epred = epred;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        mem[9] = 32'h0200_006F;  // jal x0, +0x20 at byte 0x24

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b0;

        // rst rv rpc rdy | ev epc ef addr pred
        // Reset (redirect ignored), then streaming at full rate.
        add(1, 1, 32'h40, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h00, 0, 5'h00, 0);
        add(0, 0, 0, 1, 1, 32'h00, 0, 5'h01, 0);
        add(0, 0, 0, 1, 1, 32'h04, 0, 5'h02, 0);
        add(0, 0, 0, 1, 1, 32'h08, 0, 5'h03, 0);
        add(0, 0, 0, 1, 1, 32'h0C, 0, 5'h04, 0);
        // Reset, decode stalls 5 cycles, then drains with no gap.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h00, 0, 5'h00, 0);
        add(0, 0, 0, 0, 1, 32'h00, 0, 5'h01, 0);
        add(0, 0, 0, 0, 1, 32'h00, 0, 5'h02, 0);
        add(0, 0, 0, 0, 1, 32'h00, 0, 5'h02, 0);
        add(0, 0, 0, 0, 1, 32'h00, 0, 5'h02, 0);
        add(0, 0, 0, 1, 1, 32'h00, 0, 5'h02, 0);
        add(0, 0, 0, 1, 1, 32'h04, 0, 5'h03, 0);
        add(0, 0, 0, 1, 1, 32'h08, 0, 5'h04, 0);
        // Redirect to 0x40 with two entries buffered.
        add(0, 1, 32'h40, 0, 1, 32'h0C, 0, 5'h05, 0);
        add(0, 0, 0, 1, 0, 32'h00, 0, 5'h10, 0);
        add(0, 0, 0, 1, 1, 32'h40, 0, 5'h11, 0);
        // Misaligned redirect -> FAULT, recover via aligned redirect to 0x24 (jal).
        add(0, 1, 32'h42, 1, 1, 32'h44, 0, 5'h12, 0);
        add(0, 0, 0, 1, 0, 32'h00, 1, 5'h12, 0);
        add(0, 0, 0, 1, 0, 32'h00, 1, 5'h12, 0);
        add(0, 1, 32'h24, 1, 0, 32'h00, 1, 5'h12, 0);
        add(0, 0, 0, 1, 0, 32'h00, 0, 5'h09, 0);
        add(0, 0, 0, 1, 1, 32'h24, 0, a5(JT), PRED);
        add(0, 0, 0, 1, 1, JT, 0, a5(JT + 32'd4), 0);
        // Redirect to 0x74, fill while stalled at pc 0x7C, release across the wrap.
        add(0, 1, 32'h74, 0, 1, JT + 32'd4, 0, a5(JT + 32'd8), 0);
        add(0, 0, 0, 0, 0, 32'h00, 0, 5'h1D, 0);
        add(0, 0, 0, 0, 1, 32'h74, 0, 5'h1E, 0);
        add(0, 0, 0, 0, 1, 32'h74, 0, 5'h1F, 0);
        add(0, 0, 0, 1, 1, 32'h74, 0, 5'h1F, 0);
        add(0, 0, 0, 1, 1, 32'h78, 0, 5'h00, 0);
        add(0, 0, 0, 1, 1, 32'h7C, 0, 5'h01, 0);
        add(0, 0, 0, 1, 1, 32'h80, 0, 5'h02, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] ei;
            v = vecs[i];
            rst_n              = !v.rst;
            bus.redirect_valid = v.rv;
            bus.redirect_pc    = v.rpc;
            bus.if_ready       = v.rdy;
            #2;
            if (!v.rst) begin
                ei = v.ev ? mem[v.epc[6:2]] : 32'h0;
                check($sformatf("row%0d if_valid", i), {31'b0, bus.if_valid}, {31'b0, v.ev});
                check($sformatf("row%0d if_pc", i), bus.if_pc, v.ev ? v.epc : 32'h0);
                check($sformatf("row%0d if_instr", i), bus.if_instr, ei);
                check($sformatf("row%0d if_fault", i), {31'b0, bus.if_fault}, {31'b0, v.ef});
                check($sformatf("row%0d imem_addr", i), {27'b0, bus.imem_addr},
                      {27'b0, v.eaddr});
`ifdef JAL_PREDICT_EN
                check($sformatf("row%0d if_predicted", i), {31'b0, bus.if_predicted},
                      {31'b0, v.epred});
`endif
            end
            @(posedge clk);
            #1;
        end

        // Long stall: head and pc must stay frozen while decode refuses.
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i >= 1) begin
                check($sformatf("stall%0d if_pc", i), bus.if_pc, 32'h0);
                check($sformatf("stall%0d if_instr", i), bus.if_instr, 32'hA000_0000);
                check($sformatf("stall%0d imem_addr", i), {27'b0, bus.imem_addr}, 32'h2);
            end
        end

        // Misaligned redirect with a full buffer; pops are then ignored in FAULT.
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0003;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fault%0d if_fault", i), {31'b0, bus.if_fault}, 32'h1);
            check($sformatf("fault%0d if_valid", i), {31'b0, bus.if_valid}, 32'h0);
            check($sformatf("fault%0d imem_addr", i), {27'b0, bus.imem_addr}, 32'h2);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
